// File: rtl/uart_serial_port.sv
// Full-duplex 8N1 UART endpoint: independent byte transmitter and receiver
// sharing one clock, with a fixed integer number of clocks per serial bit.
module uart_serial_port #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tx_start_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_active_o,
  output logic       tx_serial_o,
  output logic       tx_done_o,
  input  logic       rx_serial_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

  txState_t        txState_q;
  logic [CW-1:0]   txCnt_q;
  logic [2:0]      txBit_q;
  logic [7:0]      txByte_q;
  logic            txSerial_q;
  logic            txActive_q;
  logic            txDone_q;

  rxState_t        rxState_q;
  logic [1:0]      rxSync_q;
  logic [CW-1:0]   rxCnt_q;
  logic [2:0]      rxBit_q;
  logic [7:0]      rxShift_q;
  logic [7:0]      rxData_q;
  logic            rxValid_q;
  logic            rxFrameErr_q;
  logic            rxLine;

  assign tx_serial_o = txSerial_q;
  assign tx_active_o = txActive_q;
  assign tx_done_o   = txDone_q;
  assign rx_valid_o  = rxValid_q;
  assign rx_data_o   = rxData_q;
  assign rxLine      = rxSync_q[1];

  // Line level is registered so the serial pin never glitches between bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      txState_q  <= TX_IDLE;
      txCnt_q    <= '0;
      txBit_q    <= '0;
      txByte_q   <= '0;
      txSerial_q <= 1'b1;
      txActive_q <= 1'b0;
      txDone_q   <= 1'b0;
    end else begin
      txDone_q <= 1'b0;
      case (txState_q)
        TX_IDLE: begin
          if (tx_start_i) begin
            txByte_q   <= tx_data_i;
            txSerial_q <= 1'b0;
            txActive_q <= 1'b1;
            txCnt_q    <= '0;
            txState_q  <= TX_START;
          end
        end
        TX_START: begin
          if (txCnt_q == LAST) begin
            txCnt_q    <= '0;
            txBit_q    <= '0;
            txSerial_q <= txByte_q[0];
            txState_q  <= TX_DATA;
          end else begin
            txCnt_q <= txCnt_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (txCnt_q == LAST) begin
            txCnt_q <= '0;
            txBit_q <= txBit_q + 1'b1;
            if (txBit_q == 3'd7) begin
              txSerial_q <= 1'b1;
              txState_q  <= TX_STOP;
            end else begin
              txSerial_q <= txByte_q[txBit_q + 3'd1];
            end
          end else begin
            txCnt_q <= txCnt_q + 1'b1;
          end
        end
        TX_STOP: begin
          if (txCnt_q == LAST) begin
            txCnt_q    <= '0;
            txActive_q <= 1'b0;
            txDone_q   <= 1'b1;
            txState_q  <= TX_IDLE;
          end else begin
            txCnt_q <= txCnt_q + 1'b1;
          end
        end
        default: txState_q <= TX_IDLE;
      endcase
    end
  end

  // A low stop sample marks the frame bad; we then idle in STOP until the line recovers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rxState_q    <= RX_IDLE;
      rxSync_q     <= 2'b11;
      rxCnt_q      <= '0;
      rxBit_q      <= '0;
      rxShift_q    <= '0;
      rxData_q     <= '0;
      rxValid_q    <= 1'b0;
      rxFrameErr_q <= 1'b0;
    end else begin
      rxSync_q  <= {rxSync_q[0], rx_serial_i};
      rxValid_q <= 1'b0;
      case (rxState_q)
        RX_IDLE: begin
          if (!rxLine) begin
            rxCnt_q   <= '0;
            rxState_q <= RX_START;
          end
        end
        RX_START: begin
          if (rxCnt_q == MID) begin
            rxCnt_q   <= '0;
            rxBit_q   <= '0;
            rxState_q <= rxLine ? RX_IDLE : RX_DATA;
          end else begin
            rxCnt_q <= rxCnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rxCnt_q == LAST) begin
            rxCnt_q   <= '0;
            rxShift_q <= {rxLine, rxShift_q[7:1]};
            rxBit_q   <= rxBit_q + 1'b1;
            if (rxBit_q == 3'd7) begin
              rxState_q <= RX_STOP;
            end
          end else begin
            rxCnt_q <= rxCnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (rxCnt_q != LAST) begin
            rxCnt_q <= rxCnt_q + 1'b1;
          end else if (rxLine) begin
            if (!rxFrameErr_q) begin
              rxData_q  <= rxShift_q;
              rxValid_q <= 1'b1;
            end
            rxFrameErr_q <= 1'b0;
            rxCnt_q      <= '0;
            rxState_q    <= RX_IDLE;
          end else begin
            rxFrameErr_q <= 1'b1;
          end
        end
        default: rxState_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_serial_port.sv
// Bench for uart_serial_port: a 4-clock/bit instance in loopback and an
// 8-clock/bit instance whose receiver is driven by a behavioural serial source.
module tb_uart_serial_port;

  localparam int CPB4 = 4;
  localparam int CPB8 = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx4Start, tx4Active, tx4Serial, tx4Done, rx4Valid;
  logic [7:0] tx4Data, rx4Data;
  logic       tx8Start, tx8Active, tx8Serial, tx8Done, rx8Valid, rx8Drive;
  logic [7:0] tx8Data, rx8Data;

  typedef struct {
    logic [7:0] txByte;
    logic [9:0] wave;
    logic       b2b;
    logic       busy;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] rx4Got[$];
  logic [7:0] rx8Got[$];
  logic [7:0] exp4[$];
  logic [7:0] exp8[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  uart_serial_port #(.CLKS_PER_BIT(CPB4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .tx_start_i(tx4Start), .tx_data_i(tx4Data),
    .tx_active_o(tx4Active), .tx_serial_o(tx4Serial), .tx_done_o(tx4Done),
    .rx_serial_i(tx4Serial), .rx_valid_o(rx4Valid), .rx_data_o(rx4Data)
  );

  uart_serial_port #(.CLKS_PER_BIT(CPB8)) dut8 (
    .clk_i(clk), .rst_i(rst),
    .tx_start_i(tx8Start), .tx_data_i(tx8Data),
    .tx_active_o(tx8Active), .tx_serial_o(tx8Serial), .tx_done_o(tx8Done),
    .rx_serial_i(rx8Drive), .rx_valid_o(rx8Valid), .rx_data_o(rx8Data)
  );

  // Every received byte is logged so frame counts and order can be scored later.
  always @(negedge clk) begin
    if (rx4Valid) rx4Got.push_back(rx4Data);
    if (rx8Valid) rx8Got.push_back(rx8Data);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    tx4Start = 1'b1;
    tx4Data  = b;
    @(negedge clk);
    tx4Start = 1'b0;
  endtask

  task automatic sendFrame4(input logic [7:0] b, input logic [9:0] wave, input logic busy);
    logic [39:0] line;
    logic [9:0]  got;
    int          unstable;
    int          notActive;
    int          earlyDone;
    unstable  = 0;
    notActive = 0;
    earlyDone = 0;
    applyStimulus(b);
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      line[k] = tx4Serial;
      if (!tx4Active) notActive++;
      if (tx4Done) earlyDone++;
      if (busy && k == 15) begin
        tx4Start = 1'b1;
        tx4Data  = 8'hFF;
      end else begin
        tx4Start = 1'b0;
      end
    end
    @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      got[j] = line[4*j];
      for (int m = 0; m < 4; m++) begin
        if (line[4*j+m] !== wave[j]) unstable++;
      end
    end
    checkOutput("txWave", {22'd0, got}, {22'd0, wave});
    checkOutput("txBitHold", unstable, 0);
    checkOutput("txActiveHeld", notActive, 0);
    checkOutput("txDoneEarly", earlyDone, 0);
    checkOutput("txDoneAt40", {31'd0, tx4Done}, 1);
    checkOutput("txActiveFall", {31'd0, tx4Active}, 0);
  endtask

  task automatic driveRx8(input logic [7:0] b, input logic stopBit, input int bitTime);
    rx8Drive = 1'b0;
    #(bitTime);
    for (int i = 0; i < 8; i++) begin
      rx8Drive = b[i];
      #(bitTime);
    end
    rx8Drive = stopBit;
    #(bitTime);
  endtask

  task automatic compareRx4();
    checkOutput("rx4Count", rx4Got.size(), exp4.size());
    for (int i = 0; i < exp4.size(); i++) begin
      if (i < rx4Got.size()) checkOutput("rx4Byte", {24'd0, rx4Got[i]}, {24'd0, exp4[i]});
    end
    rx4Got.delete();
    exp4.delete();
  endtask

  task automatic compareRx8();
    checkOutput("rx8Count", rx8Got.size(), exp8.size());
    for (int i = 0; i < exp8.size(); i++) begin
      if (i < rx8Got.size()) checkOutput("rx8Byte", {24'd0, rx8Got[i]}, {24'd0, exp8[i]});
    end
    rx8Got.delete();
    exp8.delete();
  endtask

  initial begin
    logic [7:0] b;
    int         bt;
    rst      = 1'b1;
    tx4Start = 1'b0;
    tx4Data  = 8'h00;
    tx8Start = 1'b0;
    tx8Data  = 8'h00;
    rx8Drive = 1'b1;

    vecs[0] = '{txByte: 8'hA5, wave: 10'h34A,               b2b: 1'b0, busy: 1'b0};
    vecs[1] = '{txByte: 8'h3C, wave: {1'b1, 8'h3C, 1'b0}, b2b: 1'b0, busy: 1'b1};
    vecs[2] = '{txByte: 8'h00, wave: {1'b1, 8'h00, 1'b0}, b2b: 1'b0, busy: 1'b0};
    vecs[3] = '{txByte: 8'hFF, wave: {1'b1, 8'hFF, 1'b0}, b2b: 1'b1, busy: 1'b0};
    vecs[4] = '{txByte: 8'h5A, wave: {1'b1, 8'h5A, 1'b0}, b2b: 1'b1, busy: 1'b0};
    vecs[5] = '{txByte: 8'h81, wave: {1'b1, 8'h81, 1'b0}, b2b: 1'b0, busy: 1'b0};

    repeat (3) @(negedge clk);
    checkOutput("rstTxSerial", {31'd0, tx4Serial}, 1);
    checkOutput("rstTxActive", {31'd0, tx4Active}, 0);
    checkOutput("rstTxDone", {31'd0, tx4Done}, 0);
    checkOutput("rstRxValid", {31'd0, rx4Valid}, 0);
    checkOutput("rstRxData", {24'd0, rx4Data}, 0);
    checkOutput("rstRx8Data", {24'd0, rx8Data}, 0);
    checkOutput("rstTx8Serial", {31'd0, tx8Serial}, 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idleLine", {31'd0, tx4Serial}, 1);

    $display("[TB] loopback table vectors");
    for (int i = 0; i < 6; i++) begin
      if (!vecs[i].b2b) repeat (3) @(negedge clk);
      sendFrame4(vecs[i].txByte, vecs[i].wave, vecs[i].busy);
      exp4.push_back(vecs[i].txByte);
    end
    repeat (20) @(negedge clk);
    checkOutput("txDonePulse", {31'd0, tx4Done}, 0);
    compareRx4();

    $display("[TB] loopback random bytes");
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
      sendFrame4(b, {1'b1, b, 1'b0}, 1'b0);
      exp4.push_back(b);
    end
    repeat (20) @(negedge clk);
    compareRx4();

    $display("[TB] glitch rejection");
    rx8Drive = 1'b0;
    @(negedge clk);
    rx8Drive = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("glitchNoValid", rx8Got.size(), 0);
    driveRx8(8'h81, 1'b1, 10 * CPB8);
    repeat (5) @(negedge clk);
    exp8.push_back(8'h81);
    compareRx8();
    checkOutput("rx8DataAfterGlitch", {24'd0, rx8Data}, 8'h81);

    $display("[TB] framing error");
    driveRx8(8'h42, 1'b0, 10 * CPB8);
    repeat (20) @(negedge clk);
    rx8Drive = 1'b1;
    repeat (16) @(negedge clk);
    checkOutput("frameErrNoValid", rx8Got.size(), 0);
    checkOutput("frameErrDataHeld", {24'd0, rx8Data}, 8'h81);
    driveRx8(8'h17, 1'b1, 10 * CPB8);
    repeat (5) @(negedge clk);
    exp8.push_back(8'h17);
    compareRx8();
    checkOutput("rx8DataAfterErr", {24'd0, rx8Data}, 8'h17);

    $display("[TB] random receive with rate skew");
    repeat (4) @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      b  = 8'($urandom_range(0, 255));
      bt = 78 + 2 * int'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) #($urandom_range(1, 30));
      driveRx8(b, 1'b1, bt);
      exp8.push_back(b);
    end
    #200;
    repeat (4) @(negedge clk);
    compareRx8();

    $display("[TB] reset mid-frame");
    repeat (3) @(negedge clk);
    sendFrame4(8'hE7, {1'b1, 8'hE7, 1'b0}, 1'b0);
    exp4.push_back(8'hE7);
    repeat (10) @(negedge clk);
    compareRx4();
    checkOutput("rxDataBeforeReset", {24'd0, rx4Data}, 8'hE7);
    repeat (3) @(negedge clk);
    applyStimulus(8'hF0);
    repeat (17) @(negedge clk);
    checkOutput("txBit3Low", {31'd0, tx4Serial}, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncRstSerial", {31'd0, tx4Serial}, 1);
    checkOutput("asyncRstActive", {31'd0, tx4Active}, 0);
    checkOutput("asyncRstRxData", {24'd0, rx4Data}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    sendFrame4(8'hC3, {1'b1, 8'hC3, 1'b0}, 1'b0);
    exp4.push_back(8'hC3);
    repeat (10) @(negedge clk);
    compareRx4();
    checkOutput("rxDataAfterReset", {24'd0, rx4Data}, 8'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
